// File: rtl/param_load_sequencer_if.sv
// rtl/param_load_sequencer_if.sv - parameter memory read port and one-hot word stream toward conv_top
interface param_load_sequencer_if #(
    parameter int NSEG   = 13,
    parameter int ADDR_W = 15
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [31:0]       out_data;
    logic [NSEG-1:0]   out_valid;
    logic              out_ready;

    // sequencer side: drives the read port and the output stream
    modport master (
        output mem_rd, mem_addr, out_data, out_valid,
        input  mem_data, out_ready
    );

    // memory / consumer side
    modport slave (
        input  mem_rd, mem_addr, out_data, out_valid,
        output mem_data, out_ready
    );
endinterface

// File: rtl/param_load_sequencer.sv
// rtl/param_load_sequencer.sv - streams all CNN parameter segments from one memory; optional PARAM_LOADER_CHECKSUM_EN
module param_load_sequencer #(
    parameter int                    NSEG    = 13,
    parameter int                    ADDR_W  = 15,
    parameter int                    LEN_W   = 16,
    parameter logic [NSEG*LEN_W-1:0] SEG_LEN = {16'd6, 16'd144, 16'd24, 16'd6048, 16'd28,
                                                16'd6048, 16'd24, 16'd4320, 16'd20, 16'd3600,
                                                16'd20, 16'd180, 16'd2304}
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   start,
    param_load_sequencer_if.master bus,
    output logic [3:0]             seg_idx,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            checksum
);
    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_RUN   = 2'd1;
    localparam logic [1:0]       ST_DRAIN = 2'd2;
    localparam logic [3:0]       LAST_SEG = 4'(NSEG - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        seg_q, seg_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        pend_tag_q, pend_tag_d;
    logic              done_q, done_d;

    logic [31:0]       fifo_data_q [2];
    logic [3:0]        fifo_tag_q  [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q;

    logic              launch, issue, push, pop;
    logic [3:0]        iss_seg;
    logic [LEN_W-1:0]  iss_cnt;

    function automatic logic [LEN_W-1:0] seg_len(input logic [3:0] s);
        return SEG_LEN[s*LEN_W +: LEN_W];
    endfunction

    // A launch issues address 0 of segment 0 on the same edge that leaves IDLE
    assign launch  = (state_q == ST_IDLE) && start;
    assign iss_seg = launch ? 4'd0 : seg_q;
    assign iss_cnt = launch ? seg_len(4'd0) : rd_cnt_q;
    assign push    = mem_rd_q;
    assign pop     = (count_q != 2'd0) && bus.out_ready;
    // Issue only if the word will find room: occupancy after this edge stays below 2
    assign issue   = (launch || (state_q == ST_RUN)) &&
                     (({1'b0, count_q} + {2'b00, mem_rd_q} - {2'b00, pop}) < 3'd2);

    // Issue-side sequencing: address, per-segment countdown and FSM
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        rd_cnt_d   = rd_cnt_q;
        mem_rd_d   = issue;
        mem_addr_d = mem_addr_q;
        pend_tag_d = pend_tag_q;
        done_d     = 1'b0;
        if (launch) begin
            state_d = ST_RUN;
        end
        if (issue) begin
            mem_addr_d = launch ? '0 : mem_addr_q + 1'b1;
            pend_tag_d = iss_seg;
            seg_d      = iss_seg;
            if (iss_cnt == LEN_ONE) begin
                if (iss_seg == LAST_SEG) begin
                    state_d = ST_DRAIN;
                end else begin
                    seg_d    = iss_seg + 4'd1;
                    rd_cnt_d = seg_len(iss_seg + 4'd1);
                end
            end else begin
                rd_cnt_d = iss_cnt - 1'b1;
            end
        end
        if ((state_q == ST_DRAIN) && !mem_rd_q && (count_q == 2'd1) && pop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
    end

    // Control registers; reset abandons any read still in flight
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            seg_q      <= '0;
            rd_cnt_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            pend_tag_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            rd_cnt_q   <= rd_cnt_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            pend_tag_q <= pend_tag_d;
            done_q     <= done_d;
        end
    end

    // Two-entry {data, tag} FIFO filled by returning reads, drained by the consumer
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_tag_q[0]  <= '0;
            fifo_tag_q[1]  <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus.mem_data;
                fifo_tag_q[wr_ptr_q]  <= pend_tag_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_data  = fifo_data_q[rd_ptr_q];
    assign bus.out_valid = (count_q != 2'd0) ? (NSEG'(1) << fifo_tag_q[rd_ptr_q]) : '0;
    assign seg_idx       = seg_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Wrapping sum of accepted words, restarted by each launch
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            checksum_q <= '0;
        end else if (launch) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + bus.out_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_param_load_sequencer.sv
// tb/tb_param_load_sequencer.sv - scoreboard bench for param_load_sequencer with a segment-table reference model
module tb_param_load_sequencer;
    localparam int NSEG  = 13;
    localparam int TOTAL = 22766;

    logic        clk = 1'b0;
    logic        rst_;
    logic        start;
    logic        rdy;
    logic [3:0]  seg_idx;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    param_load_sequencer_if #(.NSEG(NSEG), .ADDR_W(15)) bus ();

    param_load_sequencer dut (
        .clk      (clk),
        .rst_     (rst_),
        .start    (start),
        .bus      (bus),
        .seg_idx  (seg_idx),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr [TOTAL];
    assign bus.mem_data  = (int'(bus.mem_addr) < TOTAL) ? mem_arr[bus.mem_addr] : 32'h0;
    assign bus.out_ready = rdy;

    int seg_len_tb [NSEG] = '{2304, 180, 20, 3600, 20, 4320, 24, 6048, 28, 6048, 24, 144, 6};
    int seg_start [NSEG];
    int seg_end   [NSEG];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [44:0] exp_q [$];
    logic [31:0] exp_sum;

    int issued, landed, accepted, done_cnt;
    logic            prev_rd, prev_ready;
    logic [NSEG-1:0] prev_valid;
    logic [31:0]     prev_data;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic int seg_of(input int addr);
        for (int s = 0; s < NSEG; s++) begin
            if (addr < seg_end[s]) return s;
        end
        return NSEG - 1;
    endfunction

    function automatic logic [31:0] expected_checksum();
`ifdef PARAM_LOADER_CHECKSUM_EN
        return exp_sum;
`else
        return 32'h0;
`endif
    endfunction

    task automatic push_expected();
        logic [NSEG-1:0] oh;
        exp_q.delete();
        exp_sum = '0;
        for (int i = 0; i < TOTAL; i++) begin
            oh = '0;
            oh[seg_of(i)] = 1'b1;
            exp_q.push_back({oh, mem_arr[i]});
            exp_sum = exp_sum + mem_arr[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_rd"}, bus.mem_rd, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_seg_idx"}, seg_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: occupancy model, address order, issue segment, hold-while-stalled, scoreboard pops
    initial begin
        issued = 0; landed = 0; accepted = 0; done_cnt = 0;
        prev_rd = 0; prev_ready = 0; prev_valid = '0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst_ !== 1'b1) begin
                issued = 0; landed = 0; accepted = 0;
                prev_rd = 0; prev_ready = 0; prev_valid = '0; prev_data = '0;
            end else begin
                logic [44:0] e;
                if (start && !busy) begin
                    issued = 0; landed = 0; accepted = 0;
                end
                if (prev_rd) landed++;
                check("occupancy_plus_pending_le_2", ((landed - accepted) + int'(bus.mem_rd)) <= 2, 1);
                check("valid_iff_fifo_nonempty", bus.out_valid != 0, (landed - accepted) != 0);
                if (bus.mem_rd) begin
                    check("read_address_order", bus.mem_addr, issued);
                    issued++;
                end
                if (busy) check("issue_segment", seg_idx, seg_of(issued < TOTAL ? issued : TOTAL - 1));
                if (prev_valid != 0 && !prev_ready) begin
                    check("hold_out_valid", bus.out_valid, prev_valid);
                    check("hold_out_data", bus.out_data, prev_data);
                end
                if (bus.out_valid != 0 && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_transfer", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_valid", bus.out_valid, e[44:32]);
                        check("word_data", bus.out_data, e[31:0]);
                    end
                    accepted++;
                end
                if (done) done_cnt++;
                prev_rd    = bus.mem_rd;
                prev_ready = bus.out_ready;
                prev_valid = bus.out_valid;
                prev_data  = bus.out_data;
            end
        end
    end

    int k, d0, n, target, stall_left, stall_reads;
    bit stalled, in_stall, pulsed;

    initial begin
        rst_ = 1'b1; start = 1'b0; rdy = 1'b0;
        for (int s = 0; s < NSEG; s++) begin
            seg_start[s] = (s == 0) ? 0 : seg_end[s-1];
            seg_end[s]   = seg_start[s] + seg_len_tb[s];
        end
        for (int i = 0; i < TOTAL; i++) mem_arr[i] = i;
        #2 rst_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_ = 1'b1;
        step();

        // Load 1: out_ready held high, word[i] = i
        rdy = 1'b1;
        push_expected();
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        k = cyc;
        check("start_mem_rd", bus.mem_rd, 1);
        check("start_mem_addr", bus.mem_addr, 0);
        check("start_busy", busy, 1);
        check("start_no_valid_yet", bus.out_valid, 0);
        step();
        check("first_out_valid", bus.out_valid, 1);
        check("first_out_data", bus.out_data, mem_arr[0]);
        wait_done(30000);
        check("done_edge_after_start", cyc - k, TOTAL + 1);
        check("busy_low_at_done", busy, 0);
        check("words_accepted", accepted, TOTAL);
        check("scoreboard_drained", exp_q.size(), 0);
        check("checksum_at_done", checksum, expected_checksum());
        step();
        check("done_single_cycle", done, 0);
        check("done_pulses_load1", done_cnt - d0, 1);

        // Load 2: out_ready toggles, a 10-cycle stall in segment 3, start pulsed mid-run
        push_expected();
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        k = cyc;
        stalled = 0; in_stall = 0; pulsed = 0; n = 0; stall_left = 0; stall_reads = 0;
        while (!done && n < 50000) begin
            if (in_stall) begin
                if (bus.mem_rd) stall_reads++;
                stall_left--;
                if (stall_left == 0) begin
                    in_stall = 0;
                    check("reads_during_stall_le_2", stall_reads <= 2, 1);
                end
            end else if (!stalled && accepted >= seg_start[3] + 40) begin
                stalled = 1; in_stall = 1; stall_left = 10; stall_reads = 0;
            end
            rdy = in_stall ? 1'b0 : ~rdy;
            start = !pulsed && accepted >= 1000;
            if (start) pulsed = 1;
            step();
            n++;
        end
        start = 1'b0;
        rdy = 1'b1;
        check("done_within_budget_toggle", done, 1);
        check("stall_exercised", stalled, 1);
        check("toggle_load_cycles", (cyc - k >= 2 * TOTAL) && (cyc - k <= 2 * TOTAL + 60), 1);
        check("words_accepted_toggle", accepted, TOTAL);
        check("scoreboard_drained_toggle", exp_q.size(), 0);
        check("checksum_toggle", checksum, expected_checksum());
        repeat (3) step();
        check("done_pulses_load2", done_cnt - d0, 1);

        // Load 3: random data and random out_ready, reset in segment 5, then restart
        for (int i = 0; i < TOTAL; i++) mem_arr[i] = $urandom;
        push_expected();
        start = 1'b1;
        step();
        start = 1'b0;
        target = seg_start[5] + int'($urandom_range(10, 3000));
        n = 0;
        while (accepted < target && n < 20000) begin
            rdy = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        check("reached_segment5", accepted >= target, 1);
        #2 rst_ = 1'b0;
        #1;
        check_reset_values("abort");
        exp_q.delete();
        step();
        step();
        rst_ = 1'b1;
        step();
        rdy = 1'b1;
        push_expected();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_mem_rd", bus.mem_rd, 1);
        check("restart_mem_addr", bus.mem_addr, 0);
        step();
        check("restart_out_valid", bus.out_valid, 1);
        check("restart_out_data", bus.out_data, mem_arr[0]);
        repeat (300) step();
        check("restart_rate", accepted, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
